// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the multi-cycle multiply/divide unit.
//   op_t    : issue op codes presented on the op port
//   state_t : sequencing states of the long-operation engine
//   DIV0_LO : quotient value reported for a divide by zero
// Helper functions classify op codes so the top and sub-module agree on
// which ops are long-running, signed, or divides.
// ----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Wide enough for any practical DATA_W; users slice the low bits.
    localparam logic [63:0] DIV0_LO = '1;

    // Multiply and divide ops occupy the engine for the full iteration run.
    function automatic logic is_long_op(input op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // Signed variants need operand magnitudes and a final sign correction.
    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
// Combinational single-iteration datapath shared by multiply and divide.
// Ports:
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : partial accumulator (upper product half / partial remainder)
//   opr      : operand register (multiplier bits / dividend-quotient bits)
//   operand  : fixed operand (multiplicand magnitude / divisor magnitude)
//   acc_next : accumulator after this iteration
//   opr_next : operand register after this iteration
// ----------------------------------------------------------------------------
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] opr,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] opr_next
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift {carry, acc, opr} right so the product grows into opr from
    // the top while consumed multiplier bits fall off the bottom.
    // Divide: shift the next dividend bit into the remainder; if the divisor
    // fits, subtract it and record a 1 quotient bit in the vacated LSB.
    // The subtraction is done at DATA_W bits: when the divisor fits, the true
    // difference is below the divisor, so no information is lost.
    always_comb begin
        sum       = {1'b0, acc} + (opr[0] ? {1'b0, operand} : '0);
        rem_shift = {acc, opr[DATA_W-1]};
        fits      = (rem_shift >= {1'b0, operand});
        diff      = rem_shift[DATA_W-1:0] - operand;

        if (is_div) begin
            acc_next = fits ? diff : rem_shift[DATA_W-1:0];
            opr_next = {opr[DATA_W-2:0], fits};
        end else begin
            acc_next = sum[DATA_W:1];
            opr_next = {sum[0], opr[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers,
// plus single-cycle MFHI/MFLO/MTHI/MTLO service. Sits beside the ALU in EX.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, highest priority
//   start    : one-cycle issue strobe, honoured only while idle
//   op       : op code (see muldiv_pkg::op_t)
//   in1      : rs operand (multiplicand / dividend / MT source)
//   in2      : rt operand (multiplier / divisor)
//   busy     : long operation in flight
//   done     : one-cycle pulse, HI/LO updated by a long op
//   rd_data  : registered MFHI/MFLO result
//   rd_valid : one-cycle pulse qualifying rd_data
//   hi, lo   : architectural HI and LO
// Timing: a long op accepted at edge E0 iterates on E1..E(DATA_W), then the
// FIX state writes HI/LO and pulses done at E(DATA_W+1).
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    count;
    logic                last_iter;

    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   opr;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]   opr_next;

    logic                is_div_q;
    logic                neg_q;
    logic                neg_r;
    logic                div0_q;
    logic [DATA_W-1:0]   in1_raw;

    op_t                 op_in;
    logic                in1_neg;
    logic                in2_neg;
    logic [DATA_W-1:0]   in1_mag;
    logic [DATA_W-1:0]   in2_mag;

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   hi_fix;
    logic [DATA_W-1:0]   lo_fix;

    assign op_in     = op_t'(op);
    assign busy      = (state != IDLE);
    assign last_iter = (count == CNT_W'(DATA_W - 1));

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc),
        .opr      (opr),
        .operand  (operand),
        .acc_next (acc_next),
        .opr_next (opr_next)
    );

    // Operand magnitudes at issue time; the engine only ever works on
    // unsigned values and restores signs in FIX.
    always_comb begin
        in1_neg = is_signed_op(op_in) && in1[DATA_W-1];
        in2_neg = is_signed_op(op_in) && in2[DATA_W-1];
        in1_mag = in1_neg ? (~in1 + 1'b1) : in1;
        in2_mag = in2_neg ? (~in2 + 1'b1) : in2;
    end

    // Sign correction and result selection applied on the FIX edge.
    // Divide by zero bypasses the datapath result entirely so signed and
    // unsigned forms report the same fixed pattern.
    always_comb begin
        prod_fix = neg_q ? (~{acc, opr} + 1'b1) : {acc, opr};
        quo_fix  = neg_q ? (~opr + 1'b1) : opr;
        rem_fix  = neg_r ? (~acc + 1'b1) : acc;
        hi_fix   = prod_fix[2*DATA_W-1:DATA_W];
        lo_fix   = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                hi_fix = in1_raw;
                lo_fix = DIV0_LO[DATA_W-1:0];
            end else begin
                hi_fix = rem_fix;
                lo_fix = quo_fix;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: only long ops leave IDLE; RUN lasts exactly DATA_W
    // iterations and FIX is a single cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && is_long_op(op_in)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath, HI/LO and handshake registers. Issue is sampled only in
    // IDLE, so a start during RUN/FIX has no effect on any register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            opr      <= '0;
            operand  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0_q   <= 1'b0;
            in1_raw  <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_in)
                            OP_MULT, OP_MULTU: begin
                                acc      <= '0;
                                opr      <= in2_mag;
                                operand  <= in1_mag;
                                is_div_q <= 1'b0;
                                neg_q    <= in1_neg ^ in2_neg;
                                neg_r    <= 1'b0;
                                div0_q   <= 1'b0;
                                in1_raw  <= in1;
                                count    <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= '0;
                                opr      <= in1_mag;
                                operand  <= in2_mag;
                                is_div_q <= 1'b1;
                                neg_q    <= in1_neg ^ in2_neg;
                                neg_r    <= in1_neg;
                                div0_q   <= (in2 == '0);
                                in1_raw  <= in1;
                                count    <= '0;
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: begin
                                hi <= in1;
                            end
                            OP_MTLO: begin
                                lo <= in1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    opr   <= opr_next;
                    count <= count + 1'b1;
                end
                FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    done  <= 1'b1;
                    count <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit. Stimulus pushes expected HI/LO or
// rd_data (from a plain-arithmetic reference model) into queues; a monitor
// on the falling edge pops and compares whenever done or rd_valid appears,
// also checking latency and busy duration.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue_edge;
    } long_exp_t;

    typedef struct {
        logic [31:0] data;
        int          issue_edge;
    } rd_exp_t;

    long_exp_t   long_q[$];
    rd_exp_t     rd_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edge_count   = 0;
    int          busy_cycles  = 0;
    logic [31:0] model_hi     = '0;
    logic [31:0] model_lo     = '0;

    muldiv_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    // Reference model: {hi, lo} for a long op, from ordinary arithmetic.
    function automatic logic [63:0] model_long(input logic [2:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sp;
        int     sa;
        int     sb;
        if (o == OP_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
        end
        if (o == OP_MULTU) begin
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (o == OP_DIVU) begin
            return {a % b, a / b};
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for the unit to go idle, issues one op, updates the
    // model and queues the expected response.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [63:0] r;
        int          guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("busy_timeout", busy, 0);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r        = model_long(o, a, b);
                model_hi = r[63:32];
                model_lo = r[31:0];
                long_q.push_back('{r[63:32], r[31:0], edge_count});
            end
            OP_MFHI: rd_q.push_back('{model_hi, edge_count});
            OP_MFLO: rd_q.push_back('{model_lo, edge_count});
            OP_MTHI: model_hi = a;
            default: model_lo = a;
        endcase
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        in1   = $urandom;
        in2   = $urandom;
    endtask

    // Monitor: compares every done / rd_valid pulse against the scoreboard.
    always @(negedge clk) begin
        long_exp_t le;
        rd_exp_t   re;
        if (reset) begin
            busy_cycles = 0;
        end else begin
            if (busy) busy_cycles++;
            if (done) begin
                if (long_q.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    le = long_q.pop_front();
                    checkOutput("hi", hi, le.hi);
                    checkOutput("lo", lo, le.lo);
                    checkOutput("done_latency", edge_count - le.issue_edge, 34);
                    checkOutput("busy_cycles", busy_cycles, 33);
                end
                busy_cycles = 0;
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    re = rd_q.pop_front();
                    checkOutput("rd_data", rd_data, re.data);
                    checkOutput("rd_latency", edge_count - re.issue_edge, 1);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          guard;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_rd_data", rd_data, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(OP_DIVU,  32'd100, 32'd7);
        applyStimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        applyStimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(OP_DIVU,  32'h0000_1234, 32'd0);

        // An issue attempt while busy must leave HI untouched.
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        in1   = 32'hAA;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("hi_after_ignored_mthi", hi, 32'h1234);

        applyStimulus(OP_MTLO, 32'h55, 32'd0);
        checkOutput("lo_after_mtlo", lo, 32'h55);
        checkOutput("busy_after_mtlo", busy, 0);
        applyStimulus(OP_MFLO, 32'd0, 32'd0);
        checkOutput("busy_after_mflo", busy, 0);
        applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        checkOutput("hi_after_mthi", hi, 32'hDEAD_BEEF);
        applyStimulus(OP_MFHI, 32'd0, 32'd0);

        // Reset during RUN iteration 10: no done, HI/LO cleared.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        in1   = 32'd1234;
        in2   = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        @(negedge clk);
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        applyStimulus(OP_MULT, 32'd6, 32'd7);

        // Randomized mix, including back-to-back issue on the done cycle.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 16);
                default: b = $urandom;
            endcase
            applyStimulus(3'($urandom_range(0, 7)), a, b);
        end

        guard = 0;
        while ((long_q.size() != 0 || rd_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("queues_drained", long_q.size() + rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO registers; responder on the execute stage's start/busy/done issue handshake.
- Complements the single-cycle combinational ALU; the pipeline stalls on busy.
- Also serves MFHI/MFLO/MTHI/MTLO.
- Sits beside the ALU in EX; rd_data muxes into the writeback result path.

Parameters:
- DATA_W, 32, operand/HI/LO width; fixed at 32 for MIPS, kept for bench scaling.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  issue strobe, valid for one cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
- in1  input  DATA_W  rs operand (multiplicand/dividend/MT source)
- in2  input  DATA_W  rt operand (multiplier/divisor)
- busy  output  1  long operation in flight; start ignored while high
- done  output  1  one-cycle pulse; HI/LO updated this cycle
- rd_data  output  DATA_W  registered MFHI/MFLO result
- rd_valid  output  1  one-cycle pulse qualifying rd_data
- hi  output  DATA_W  architectural HI
- lo  output  DATA_W  architectural LO

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: busy 0, done 0, rd_valid 0, rd_data 0, hi 0, lo 0, FSM in IDLE, counter 0.
- Reset has priority over every other input. If asserted mid-operation, the FSM returns to IDLE at that edge, hi/lo clear, and no done pulse is produced.
- FSM states: IDLE, RUN, FIX.
  - IDLE: start is accepted only here.
  - RUN: exactly DATA_W iterations.
  - FIX: one cycle to apply sign correction.
- Ops 0-3 accepted at edge E0:
  - Latch |in1| and |in2| (signed ops only) and the result signs; go to RUN; busy=1 from E0.
  - Iteration k is performed at edge E1+k, for k=0..DATA_W-1.
  - At edge E(DATA_W+1), go FIX→IDLE: hi/lo are written, done=1 for one cycle, busy=0.
  - Total latency from start to done is DATA_W+2 = 34 edges.
- A start in the same cycle that done is high is accepted, giving back-to-back operation.
- Multiply: shift-add over DATA_W iterations. Product is {hi,lo}. Signed result is negated in FIX if sign(in1)^sign(in2).
- Divide: restoring divide with one quotient bit per iteration.
  - lo = quotient, hi = remainder.
  - Signed ops: quotient sign = sign(in1)^sign(in2); remainder takes the sign of the dividend (truncating division).
- Divide by zero (in2==0): fixed result, still full latency. lo=all-ones, hi=in1 as issued.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0. This is the natural result of the magnitude algorithm.
- MFHI/MFLO accepted in IDLE: rd_data=hi or lo at the next edge, rd_valid=1 for one cycle, busy stays 0.
- MTHI/MTLO accepted in IDLE: hi or lo = in1 at the next edge; no done, no rd_valid.
- Any start while busy=1 is ignored with no side effect. The stall is the pipeline's responsibility.
- Op, operands and signs are captured at acceptance. Changes on in1/in2/op during RUN have no effect.
- hi/lo hold their values during RUN and change only at the FIX exit, on MT ops, or on reset.

Decomposition:
- Package muldiv_pkg holds:
  - op_t enum (the 8 op codes above)
  - state_t enum (IDLE, RUN, FIX)
  - localparam DIV0_LO = '1
- One natural sub-module, muldiv_step: combinational single-iteration datapath.
  - Inputs: mode, partial accumulator, operand register.
  - Outputs: next accumulator, next operand/quotient register.
  - The top keeps the FSM, counter, sign latches, hi/lo and handshake.

Test Plan:
- MULT in1=0xFFFFFFFD (-3), in2=5 → done at edge 34 after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles before done.
- MULTU in1=in2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIVU 100/7 → lo=14, hi=2.
- DIV in1=0xFFFFFFF9 (-7), in2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234 after full latency. A second start pulsed mid-operation (MTHI 0xAA) is ignored: hi ≠ 0xAA.
- MTLO 0x55, then MFLO next cycle → lo=0x55 one edge after MTLO; rd_data=0x55 with rd_valid one edge after MFLO; busy never asserts.
- Reset asserted at RUN iteration 10 → next edge: busy=0, hi=lo=0, no done. A MULT 6*7 issued after reset release yields lo=42, hi=0.
